// File: rtl/pwm_seq_pkg.sv
// Shared types and defaults for the PWM soft-start sequencer.
package pwm_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RAMP_UP,
    RUN,
    RAMP_DOWN,
    FAULT
  } seq_state_t;

  localparam int unsigned DEF_RAMP_DIV = 16;

endpackage

// File: rtl/ramp_tick_gen.sv
// Ramp prescaler: counts 0..RAMP_DIV-1 while enabled, pulses tick on the last count.
module ramp_tick_gen
  import pwm_seq_pkg::*;
#(
  parameter int unsigned RAMP_DIV = DEF_RAMP_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(RAMP_DIV - 1);

  logic [CW-1:0] r_count;

  assign tick = en && (r_count == LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (clr || !en || tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/pwm_softstart_seq.sv
// Soft-start / soft-stop sequencer driving pwm ena/duty, with latched hard-stop on fault.
module pwm_softstart_seq
  import pwm_seq_pkg::*;
#(
  parameter int unsigned N        = 8,
  parameter int unsigned RAMP_DIV = DEF_RAMP_DIV
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic [N-1:0] target_duty,
  input  logic [N-1:0] step,
  input  logic         fault,
  input  logic         fault_clr,
  output logic         pwm_ena,
  output logic [N-1:0] pwm_duty,
  output logic         running,
  output logic         fault_latched
);

  seq_state_t   r_state, w_state_next;
  logic [N-1:0] r_duty, w_duty_next;
  logic [N-1:0] r_target, w_target_next;
  logic [N-1:0] r_step, w_step_next;
  logic         r_ena, w_ena_next;
  logic         r_running, w_running_next;
  logic         r_fault, w_fault_next;

  logic         w_tick;
  logic         w_in_ramp;
  logic [N:0]   w_sum;
  logic [N-1:0] w_up_duty;
  logic [N-1:0] w_down_duty;

  assign w_in_ramp = (r_state == RAMP_UP) || (r_state == RAMP_DOWN);

  // Any state change restarts the prescaler so each ramp's first tick is RAMP_DIV cycles out.
  ramp_tick_gen #(
    .RAMP_DIV(RAMP_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (w_state_next != r_state),
    .en  (w_in_ramp),
    .tick(w_tick)
  );

  // The extra sum bit lets the clamp to target see an overflow instead of a wrapped value.
  assign w_sum       = {1'b0, r_duty} + {1'b0, r_step};
  assign w_up_duty   = (w_sum >= {1'b0, r_target}) ? r_target : w_sum[N-1:0];
  assign w_down_duty = (r_duty > r_step) ? (r_duty - r_step) : '0;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next   = r_state;
    w_duty_next    = r_duty;
    w_target_next  = r_target;
    w_step_next    = r_step;
    w_ena_next     = r_ena;
    w_running_next = r_running;
    w_fault_next   = r_fault;

    if (fault) begin
      w_state_next   = FAULT;
      w_ena_next     = 1'b0;
      w_duty_next    = '0;
      w_running_next = 1'b0;
      w_fault_next   = 1'b1;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (!stop && start && (target_duty != '0)) begin
            w_target_next = target_duty;
            w_step_next   = (step == '0) ? N'(1) : step;
            w_state_next  = RAMP_UP;
            w_ena_next    = 1'b1;
            w_duty_next   = '0;
          end
        end
        RAMP_UP: begin
          if (stop) begin
            w_state_next = RAMP_DOWN;
          end else if (w_tick) begin
            w_duty_next = w_up_duty;
            if (w_up_duty == r_target) begin
              w_state_next   = RUN;
              w_running_next = 1'b1;
            end
          end
        end
        RUN: begin
          w_ena_next     = 1'b1;
          w_duty_next    = r_target;
          w_running_next = 1'b1;
          if (stop) begin
            w_state_next   = RAMP_DOWN;
            w_running_next = 1'b0;
          end
        end
        RAMP_DOWN: begin
          if (w_tick) begin
            w_duty_next = w_down_duty;
            if (w_down_duty == '0) begin
              w_state_next = IDLE;
              w_ena_next   = 1'b0;
            end
          end
        end
        FAULT: begin
          if (fault_clr) begin
            w_state_next = IDLE;
            w_fault_next = 1'b0;
          end
        end
        default: begin
          w_state_next   = IDLE;
          w_ena_next     = 1'b0;
          w_duty_next    = '0;
          w_running_next = 1'b0;
          w_fault_next   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_duty    <= '0;
      r_target  <= '0;
      r_step    <= '0;
      r_ena     <= 1'b0;
      r_running <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_duty    <= w_duty_next;
      r_target  <= w_target_next;
      r_step    <= w_step_next;
      r_ena     <= w_ena_next;
      r_running <= w_running_next;
      r_fault   <= w_fault_next;
    end
  end

  assign pwm_ena       = r_ena;
  assign pwm_duty      = r_duty;
  assign running       = r_running;
  assign fault_latched = r_fault;

endmodule
